control_sequencer: RTL

//  Multicycle main-control FSM; produces the 4-bit state consumed by the

---
 rtl/control_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Multicycle main-control FSM for the lb/sb/addi/R-type/beq/j datapath.
// Emits the state code plus ALU selects, memory request and PC/IR enables.
module control_sequencer #(
    parameter int MEM_TIMEOUT     = 0,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic [2:0] alucont,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       mem_req,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic       halted,
    output logic       timeout_err
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        LBRD    = 4'd3,
        SBWR    = 4'd4,
        RTYPEEX = 4'd5,
        ADDIEX  = 4'd6,
        BEQEX   = 4'd7,
        JEX     = 4'd8,
        HALT    = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam bit          TIMEOUT_ON = (MEM_TIMEOUT > 0);
    localparam logic [15:0] CNT_LAST   = TIMEOUT_ON ? 16'(MEM_TIMEOUT - 1) : 16'd0;

    state_t      state_q;
    logic [15:0] wait_cnt;
    logic [5:0]  op_q;
    logic        illegal;
    logic [2:0]  funct_alucont;
    state_t      decode_next;
    logic        mem_wait;
    logic        to_expire;

    // Instruction classification; only meaningful while state is DECODE.
    always_comb begin
        funct_alucont = 3'b010;
        illegal       = 1'b1;
        decode_next   = HALT_ON_ILLEGAL ? HALT : FETCH;
        case (funct)
            FN_ADD:  funct_alucont = 3'b010;
            FN_SUB:  funct_alucont = 3'b110;
            FN_AND:  funct_alucont = 3'b000;
            FN_OR:   funct_alucont = 3'b001;
            FN_SLT:  funct_alucont = 3'b111;
            default: funct_alucont = 3'b010;
        endcase
        case (op)
            OP_RTYPE: begin
                if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
                    illegal     = 1'b0;
                    decode_next = RTYPEEX;
                end
            end
            OP_LB, OP_SB: begin
                illegal     = 1'b0;
                decode_next = MEMADR;
            end
            OP_ADDI: begin
                illegal     = 1'b0;
                decode_next = ADDIEX;
            end
            OP_BEQ: begin
                illegal     = 1'b0;
                decode_next = BEQEX;
            end
            OP_J: begin
                illegal     = 1'b0;
                decode_next = JEX;
            end
            default: ;
        endcase
    end

    // A ready on the last allowed cycle beats the timeout.
    assign mem_wait  = (state_q == FETCH) || (state_q == LBRD) || (state_q == SBWR);
    assign to_expire = TIMEOUT_ON && mem_wait && !mem_ready && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            wait_cnt    <= 16'd0;
            op_q        <= 6'd0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= 16'd0;
            if (to_expire) begin
                state_q     <= HALT;
                timeout_err <= 1'b1;
            end else begin
                case (state_q)
                    FETCH: begin
                        if (mem_ready) state_q <= DECODE;
                        else           wait_cnt <= wait_cnt + 16'd1;
                    end
                    DECODE: begin
                        op_q    <= op;
                        state_q <= decode_next;
                    end
                    MEMADR:  state_q <= (op_q == OP_LB) ? LBRD : SBWR;
                    LBRD, SBWR: begin
                        if (mem_ready) state_q <= FETCH;
                        else           wait_cnt <= wait_cnt + 16'd1;
                    end
                    RTYPEEX, ADDIEX, BEQEX, JEX: state_q <= FETCH;
                    HALT:    state_q <= HALT;
                    default: state_q <= HALT;
                endcase
            end
        end
    end

    assign state = state_q;

    always_comb begin
        alucont  = 3'b010;
        alusrca  = 1'b0;
        alusrcb  = 2'b01;
        mem_req  = 1'b0;
        ir_write = 1'b0;
        pc_en    = 1'b0;
        pc_src   = 2'b00;
        retire   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_en    = mem_ready;
            end
            DECODE:  retire = illegal && !HALT_ON_ILLEGAL;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            LBRD, SBWR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                mem_req = 1'b1;
                retire  = mem_ready;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                alucont = funct_alucont;
                retire  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                retire  = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                alucont = 3'b110;
                pc_src  = 2'b01;
                pc_en   = zero;
                retire  = 1'b1;
            end
            JEX: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule
